// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg
//   Shared definitions for the direct-mapped instruction cache:
//   - state_t      : refill FSM state encoding (IDLE=0, REFILL=1)
//   - ADDR_W       : width of the fetch word address, bits [31:2]
//   - NOP_WORD_DEF : default word returned whenever there is no hit (addi x0,x0,0)
//   - off_width / idx_width / tag_width : derived address-field widths
package icache_direct_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam int          ADDR_W       = 30;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int line_words, input int sets);
        return ADDR_W - $clog2(line_words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// icache_data_array
//   SETS x LINE_WORDS x 32-bit instruction storage. Kept separate so it can
//   be mapped onto LUTRAM or BRAM without touching the cache control.
//   Ports:
//     clk       : clock, rising edge (write port only)
//     wr_en     : write one word this cycle
//     wr_idx    : set to write
//     wr_off    : word within the line to write
//     wr_data   : word to write
//     rd_idx    : set to read
//     rd_off    : word within the line to read
//     rd_data   : combinational read data
module icache_data_array #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic [31:0]      rd_data
);

    // Contents are deliberately not reset; valid bits in the controller
    // guard every read.
    logic [31:0] mem [SETS][LINE_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx][wr_off] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx][rd_off];

endmodule

// File: rtl/icache_direct.sv
// icache_direct
//   Direct-mapped, blocking instruction cache in front of the fetch stage.
//   Hits are served combinationally in the same cycle; a miss stalls fetch
//   (blocking_n_o=0) while the whole line is refilled word 0..LINE_WORDS-1
//   from the memory port. flush_i invalidates every line (FENCE.I).
//
//   Memory handshake: mem_req_o is held high with a stable mem_addr_o until
//   the cycle mem_ack_i is seen; in that cycle mem_rdata_i carries the word
//   and the transfer completes. Only one request is ever outstanding and the
//   request may be withdrawn by reset at any time.
//
//   Ports:
//     clk_i        : clock, rising edge
//     rst_ni       : asynchronous active-low reset
//     address_i    : fetch word address [31:2]
//     read_data_o  : instruction word, NOP_WORD when not a hit
//     blocking_n_o : 1 = hit, read_data_o valid this cycle
//     flush_i      : one-cycle pulse, invalidates all lines
//     mem_req_o    : memory word-read request
//     mem_addr_o   : word address of the request [31:2]
//     mem_ack_i    : memory accepted request, mem_rdata_i valid
//     mem_rdata_i  : returned word
//     dbg_state    : current FSM state
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter int          SETS       = 64,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:2] address_i,
    output logic [31:0] read_data_o,
    output logic        blocking_n_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:2] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output state_t      dbg_state
);

    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(LINE_WORDS, SETS);

    // Address split of the incoming fetch address
    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    assign offset = address_i[OFF_W+1:2];
    assign index  = address_i[OFF_W+2 +: IDX_W];
    assign tag    = address_i[31 -: TAG_W];

    state_t           state;
    logic             mem_req_q;
    logic [IDX_W-1:0] miss_index;
    logic [TAG_W-1:0] miss_tag;
    logic [OFF_W-1:0] word_cnt;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem [SETS];

    logic             hit;
    logic             word_ack;
    logic             last_ack;
    logic [31:0]      array_rdata;

    assign hit      = (state == IDLE) && valid[index] &&
                      (tag_mem[index] == tag) && !flush_i;
    assign word_ack = (state == REFILL) && mem_ack_i;
    assign last_ack = word_ack && (word_cnt == OFF_W'(LINE_WORDS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            miss_index <= '0;
            miss_tag   <= '0;
            word_cnt   <= '0;
            valid      <= '0;
        end else begin
            // The completing refill's set survives a coincident flush:
            // memory is already coherent for that line.
            if (last_ack) begin
                valid <= (flush_i ? '0 : valid) | (SETS'(1) << miss_index);
            end else if (flush_i) begin
                valid <= '0;
            end

            case (state)
                IDLE: begin
                    if (!hit && !flush_i) begin
                        state      <= REFILL;
                        mem_req_q  <= 1'b1;
                        miss_index <= index;
                        miss_tag   <= tag;
                        word_cnt   <= '0;
                    end
                end
                REFILL: begin
                    // address_i is ignored here; the latched line always
                    // completes before a new lookup happens.
                    if (mem_ack_i) begin
                        word_cnt <= word_cnt + OFF_W'(1);
                        if (last_ack) begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Tags are not reset; the valid bits cover them.
    always_ff @(posedge clk_i) begin
        if (last_ack) begin
            tag_mem[miss_index] <= miss_tag;
        end
    end

    icache_data_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W)
    ) u_data (
        .clk     (clk_i),
        .wr_en   (word_ack),
        .wr_idx  (miss_index),
        .wr_off  (word_cnt),
        .wr_data (mem_rdata_i),
        .rd_idx  (index),
        .rd_off  (offset),
        .rd_data (array_rdata)
    );

    assign blocking_n_o = hit;
    assign read_data_o  = hit ? array_rdata : NOP_WORD;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = {miss_tag, miss_index, word_cnt};
    assign dbg_state    = state;

endmodule
